// File: rtl/arm_pkg.sv
// arm_pkg: shared constants and helpers for the ARM execute datapath.
//   - ALU command encodings (EXE_*)
//   - shifter type encodings (SH_*)
//   - NZCV status bit indices and a packed status struct
//   - ror32: 32-bit rotate-right used by the operand-2 generator
package arm_pkg;

  localparam int WORD_W = 32;
  localparam int REG_W  = 4;
  localparam int SO_W   = 12;

  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_MVN = 4'b1001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  localparam int N_BIT = 3;
  localparam int Z_BIT = 2;
  localparam int C_BIT = 1;
  localparam int V_BIT = 0;

  // Field order matches the status port: bit3 = N ... bit0 = V.
  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

  function automatic logic [WORD_W-1:0] ror32(input logic [WORD_W-1:0] v,
                                              input logic [4:0]        amt);
    logic [2*WORD_W-1:0] dbl;
    dbl = {v, v} >> amt;
    return dbl[WORD_W-1:0];
  endfunction

endpackage

// File: rtl/val2_generator.sv
// val2_generator: combinational second-operand former for the ALU.
// Ports:
//   imm            in  1   use the rotated 8-bit immediate
//   mem_access     in  1   load/store: use the sign-extended 12-bit offset
//   shift_operand  in  12  shifter operand field
//   val_Rm         in  32  register operand to be shifted
//   val2           out 32  resulting operand 2
module val2_generator
  import arm_pkg::*;
(
  input  logic              imm,
  input  logic              mem_access,
  input  logic [SO_W-1:0]   shift_operand,
  input  logic [WORD_W-1:0] val_Rm,
  output logic [WORD_W-1:0] val2
);

  logic [WORD_W-1:0]        rot_imm;
  logic [WORD_W-1:0]        mem_off;
  logic [WORD_W-1:0]        shifted;
  logic signed [WORD_W-1:0] rm_s;
  logic [4:0]               shift_amt;
  logic [1:0]               shift_type;

  assign shift_amt  = shift_operand[11:7];
  assign shift_type = shift_operand[6:5];
  assign rm_s       = val_Rm;

  // Rotation amount is twice the 4-bit field, so append a zero LSB.
  assign rot_imm = ror32({24'b0, shift_operand[7:0]}, {shift_operand[11:8], 1'b0});
  assign mem_off = {{(WORD_W-SO_W){shift_operand[SO_W-1]}}, shift_operand};

  // A zero amount falls out of every shift type unchanged, so no special case.
  always_comb begin
    shifted = val_Rm;
    case (shift_type)
      SH_LSL:  shifted = val_Rm << shift_amt;
      SH_LSR:  shifted = val_Rm >> shift_amt;
      SH_ASR:  shifted = rm_s >>> shift_amt;
      SH_ROR:  shifted = ror32(val_Rm, shift_amt);
      default: shifted = val_Rm;
    endcase
  end

  always_comb begin
    if (imm)
      val2 = rot_imm;
    else if (mem_access)
      val2 = mem_off;
    else
      val2 = shifted;
  end

endmodule

// File: rtl/exe_stage.sv
// exe_stage: execute stage of the 5-stage ARM pipeline.
// Forms operand 2, runs the ALU, keeps the NZCV status register, resolves
// branches, and registers results into the EXE/MEM register.
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   freeze              hold EXE/MEM and status (hazard stall)
//   PC_in               PC carried with the instruction
//   wb_en_in .. imm_in  decoded control bits
//   exec_cmd_in         ALU command
//   val_Rn_in/val_Rm_in register operands
//   Rd_in               destination register
//   shift_operand_in    shifter operand field
//   signed_imm_24_in    branch offset (words)
//   branch_taken        combinational, equals B_in
//   branch_addr         combinational branch target
//   status              registered NZCV
//   wb_en_out, mem_r_out, mem_w_out, alu_res_out, val_Rm_out, Rd_out
//                       EXE/MEM register outputs
module exe_stage
  import arm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic [WORD_W-1:0] PC_in,
  input  logic              wb_en_in,
  input  logic              mem_r_in,
  input  logic              mem_w_in,
  input  logic              B_in,
  input  logic              S_in,
  input  logic              imm_in,
  input  logic [3:0]        exec_cmd_in,
  input  logic [WORD_W-1:0] val_Rn_in,
  input  logic [WORD_W-1:0] val_Rm_in,
  input  logic [REG_W-1:0]  Rd_in,
  input  logic [SO_W-1:0]   shift_operand_in,
  input  logic [23:0]       signed_imm_24_in,
  output logic              branch_taken,
  output logic [WORD_W-1:0] branch_addr,
  output logic [3:0]        status,
  output logic              wb_en_out,
  output logic              mem_r_out,
  output logic              mem_w_out,
  output logic [WORD_W-1:0] alu_res_out,
  output logic [WORD_W-1:0] val_Rm_out,
  output logic [REG_W-1:0]  Rd_out
);

  function automatic logic add_ovf(input logic signed [WORD_W-1:0] a,
                                   input logic signed [WORD_W-1:0] b,
                                   input logic signed [WORD_W-1:0] r);
    return (a[WORD_W-1] == b[WORD_W-1]) && (r[WORD_W-1] != a[WORD_W-1]);
  endfunction

  function automatic logic sub_ovf(input logic signed [WORD_W-1:0] a,
                                   input logic signed [WORD_W-1:0] b,
                                   input logic signed [WORD_W-1:0] r);
    return (a[WORD_W-1] != b[WORD_W-1]) && (r[WORD_W-1] != a[WORD_W-1]);
  endfunction

  // ---- Stage p0: operand 2, ALU, flags, branch target (combinational) ----
  logic [WORD_W-1:0]        val2_p0;
  logic [WORD_W-1:0]        alu_res_p0;
  logic [WORD_W:0]          ext_p0;
  logic                     carry_q;
  logic signed [WORD_W-1:0] br_off_p0;
  nzcv_t                    flags_p0;
  nzcv_t                    status_q;

  val2_generator u_val2 (
    .imm           (imm_in),
    .mem_access    (mem_r_in | mem_w_in),
    .shift_operand (shift_operand_in),
    .val_Rm        (val_Rm_in),
    .val2          (val2_p0)
  );

  // ADC/SBC consume the carry as registered before this instruction's update.
  assign carry_q = status_q.c;

  always_comb begin
    alu_res_p0 = '0;
    ext_p0     = '0;
    flags_p0.c = status_q.c;
    flags_p0.v = status_q.v;
    case (exec_cmd_in)
      EXE_MOV: alu_res_p0 = val2_p0;
      EXE_MVN: alu_res_p0 = ~val2_p0;
      EXE_ADD, EXE_ADC: begin
        ext_p0 = {1'b0, val_Rn_in} + {1'b0, val2_p0}
               + {{WORD_W{1'b0}}, (exec_cmd_in == EXE_ADC) & carry_q};
        alu_res_p0 = ext_p0[WORD_W-1:0];
        flags_p0.c = ext_p0[WORD_W];
        flags_p0.v = add_ovf(val_Rn_in, val2_p0, alu_res_p0);
      end
      EXE_SUB, EXE_SBC: begin
        // Bit 32 of the 33-bit difference is the borrow; C is its inverse.
        ext_p0 = {1'b0, val_Rn_in} - {1'b0, val2_p0}
               - {{WORD_W{1'b0}}, (exec_cmd_in == EXE_SBC) & ~carry_q};
        alu_res_p0 = ext_p0[WORD_W-1:0];
        flags_p0.c = ~ext_p0[WORD_W];
        flags_p0.v = sub_ovf(val_Rn_in, val2_p0, alu_res_p0);
      end
      EXE_AND: alu_res_p0 = val_Rn_in & val2_p0;
      EXE_ORR: alu_res_p0 = val_Rn_in | val2_p0;
      EXE_EOR: alu_res_p0 = val_Rn_in ^ val2_p0;
      default: alu_res_p0 = '0;
    endcase
    flags_p0.n = alu_res_p0[WORD_W-1];
    flags_p0.z = (alu_res_p0 == '0);
  end

  assign br_off_p0    = {{6{signed_imm_24_in[23]}}, signed_imm_24_in, 2'b00};
  assign branch_addr  = PC_in + br_off_p0;
  assign branch_taken = B_in;

  // ---- Stage p1: status register and EXE/MEM register ----
  logic              wb_en_p1;
  logic              mem_r_p1;
  logic              mem_w_p1;
  logic [WORD_W-1:0] alu_res_p1;
  logic [WORD_W-1:0] val_Rm_p1;
  logic [REG_W-1:0]  Rd_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      status_q <= '0;
    else if (S_in && !freeze)
      status_q <= flags_p0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_en_p1   <= 1'b0;
      mem_r_p1   <= 1'b0;
      mem_w_p1   <= 1'b0;
      alu_res_p1 <= '0;
      val_Rm_p1  <= '0;
      Rd_p1      <= '0;
    end else if (!freeze) begin
      wb_en_p1   <= wb_en_in;
      mem_r_p1   <= mem_r_in;
      mem_w_p1   <= mem_w_in;
      alu_res_p1 <= alu_res_p0;
      val_Rm_p1  <= val_Rm_in;
      Rd_p1      <= Rd_in;
    end
  end

  assign status      = status_q;
  assign wb_en_out   = wb_en_p1;
  assign mem_r_out   = mem_r_p1;
  assign mem_w_out   = mem_w_p1;
  assign alu_res_out = alu_res_p1;
  assign val_Rm_out  = val_Rm_p1;
  assign Rd_out      = Rd_p1;

endmodule
